// File: rtl/jtag_az_pwm_pkg.sv
// jtag_az_pwm_pkg: FSM state type, default field widths/values, DR width and counter width helpers
package jtag_az_pwm_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} az_state_t;
  localparam int NDELAY_W_DEF = 5;
  localparam int NHIGH_W_DEF = 8;
  localparam int NLOW_W_DEF = 14;
  localparam int NDELAY_DEF_DEF = 0;
  localparam int NHIGH_DEF_DEF = 20;
  localparam int NLOW_DEF_DEF = 3980;
  function automatic int dr_width(input int nd_w, input int nh_w, input int nl_w);
    return 1 + nd_w + nh_w + nl_w;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/jtag_az_pwm_if.sv
// jtag_az_pwm_if: TAP strobes/tdi in, tdo/shadow/az/period_stb out; master = TAP side, slave = PWM block
interface jtag_az_pwm_if import jtag_az_pwm_pkg::*; #(
  parameter int W = dr_width(NDELAY_W_DEF, NHIGH_W_DEF, NLOW_W_DEF)
);
  logic capture_dr;
  logic shift_dr;
  logic update_dr;
  logic tdi;
  logic tdo;
  logic [W-1:0] shadow;
  logic az;
  logic period_stb;
  modport master (
    output capture_dr, shift_dr, update_dr, tdi,
    input  tdo, shadow, az, period_stb
  );
  modport slave (
    input  capture_dr, shift_dr, update_dr, tdi,
    output tdo, shadow, az, period_stb
  );
endinterface

// File: rtl/jtag_dr_shadow.sv
// jtag_dr_shadow: W-bit JTAG data register (capture > shift > hold) with update shadow; ports clk_i, rst_ni, capture_i, shift_i, update_i, tdi_i -> tdo_o, shadow_o
module jtag_dr_shadow #(
  parameter int W = 28,
  parameter logic [W-1:0] DEF = '0,
  parameter bit READBACK = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         capture_i,
  input  logic         shift_i,
  input  logic         update_i,
  input  logic         tdi_i,
  output logic         tdo_o,
  output logic [W-1:0] shadow_o
);
  logic [W-1:0] sr_q;
  logic [W-1:0] shadow_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q <= '0;
      shadow_q <= '0;
    end else begin
      if (capture_i) sr_q <= READBACK ? shadow_q : DEF;
      else if (shift_i) sr_q <= {tdi_i, sr_q[W-1:1]};
      if (update_i) shadow_q <= sr_q;
    end
  end
  assign tdo_o = sr_q[0];
  assign shadow_o = shadow_q;
endmodule

// File: rtl/jtag_az_pwm.sv
// jtag_az_pwm: JTAG-programmed autozero PWM; ports clk_i, rst_ni, bus (slave: strobes/tdi in, tdo/shadow/az/period_stb out)
module jtag_az_pwm import jtag_az_pwm_pkg::*; #(
  parameter int NDELAY_W = NDELAY_W_DEF,
  parameter int NHIGH_W = NHIGH_W_DEF,
  parameter int NLOW_W = NLOW_W_DEF,
  parameter int NDELAY_DEF = NDELAY_DEF_DEF,
  parameter int NHIGH_DEF = NHIGH_DEF_DEF,
  parameter int NLOW_DEF = NLOW_DEF_DEF,
  parameter bit READBACK = 1'b0
) (
  input logic clk_i,
  input logic rst_ni,
  jtag_az_pwm_if.slave bus
);
  localparam int W = dr_width(NDELAY_W, NHIGH_W, NLOW_W);
  localparam int CW = max3(NDELAY_W, NHIGH_W, NLOW_W);
  localparam logic [W-1:0] DEF = {1'b0, NLOW_W'(NLOW_DEF), NHIGH_W'(NHIGH_DEF), NDELAY_W'(NDELAY_DEF)};
  typedef struct packed {
    az_state_t st;
    logic az;
    logic stb;
    logic [CW-1:0] cnt;
  } step_t;
  logic [W-1:0] shadow;
  logic en;
  logic [NLOW_W-1:0] s_nl;
  logic [NHIGH_W-1:0] s_nh;
  logic [NDELAY_W-1:0] s_nd;
  az_state_t st_q;
  logic [CW-1:0] cnt_q;
  logic [NHIGH_W-1:0] nh_q;
  logic [NLOW_W-1:0] nl_q;
  logic az_q;
  logic stb_q;
  step_t ps_s;
  step_t ps_w;
  jtag_dr_shadow #(.W(W), .DEF(DEF), .READBACK(READBACK)) u_dr (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .capture_i(bus.capture_dr),
    .shift_i(bus.shift_dr),
    .update_i(bus.update_dr),
    .tdi_i(bus.tdi),
    .tdo_o(bus.tdo),
    .shadow_o(shadow)
  );
  assign en = shadow[W-1];
  assign s_nl = shadow[W-2 -: NLOW_W];
  assign s_nh = shadow[NHIGH_W+NDELAY_W-1 -: NHIGH_W];
  assign s_nd = shadow[NDELAY_W-1:0];
  // First cycle of a period: HIGH if it has length, else straight into LOW (with strobe if LOW is a single or empty cycle)
  function automatic step_t start_period(input logic [NHIGH_W-1:0] nh, input logic [NLOW_W-1:0] nl);
    step_t r;
    r.st = (nh != '0) ? HIGH : LOW;
    r.az = nh != '0;
    r.stb = (nh == '0) && (nl <= NLOW_W'(1));
    r.cnt = (nh != '0) ? CW'(nh - NHIGH_W'(1)) : (nl != '0) ? CW'(nl - NLOW_W'(1)) : '0;
    return r;
  endfunction
  always_comb begin
    ps_s = start_period(s_nh, s_nl);
    ps_w = start_period(nh_q, nl_q);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q <= IDLE;
      cnt_q <= '0;
      nh_q <= '0;
      nl_q <= '0;
      az_q <= 1'b0;
      stb_q <= 1'b0;
    end else if (!en) begin
      st_q <= IDLE;
      cnt_q <= '0;
      az_q <= 1'b0;
      stb_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          nh_q <= s_nh;
          nl_q <= s_nl;
          if (s_nd != '0) begin
            st_q <= DELAY;
            cnt_q <= CW'(s_nd - NDELAY_W'(1));
            az_q <= 1'b0;
            stb_q <= 1'b0;
          end else {st_q, az_q, stb_q, cnt_q} <= ps_s;
        end
        DELAY: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          else {st_q, az_q, stb_q, cnt_q} <= ps_w;
        end
        HIGH: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          else if (nl_q != '0) begin
            st_q <= LOW;
            cnt_q <= CW'(nl_q - NLOW_W'(1));
            az_q <= 1'b0;
            stb_q <= nl_q == NLOW_W'(1);
          end else begin
            // Empty LOW phase: the period boundary is here, so pick up the shadow now
            nh_q <= s_nh;
            nl_q <= s_nl;
            {st_q, az_q, stb_q, cnt_q} <= ps_s;
          end
        end
        LOW: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            stb_q <= cnt_q == CW'(1);
          end else begin
            nh_q <= s_nh;
            nl_q <= s_nl;
            {st_q, az_q, stb_q, cnt_q} <= ps_s;
          end
        end
        default: begin
          st_q <= IDLE;
          cnt_q <= '0;
          az_q <= 1'b0;
          stb_q <= 1'b0;
        end
      endcase
    end
  end
  assign bus.shadow = shadow;
  assign bus.az = az_q;
  assign bus.period_stb = stb_q;
endmodule

// File: tb/tb_jtag_az_pwm.sv
// tb_jtag_az_pwm: directed self-checking bench for jtag_az_pwm (READBACK=0 and READBACK=1 instances)
module tb_jtag_az_pwm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  jtag_az_pwm_if #(.W(28)) b0 ();
  jtag_az_pwm_if #(.W(28)) b1 ();
  jtag_az_pwm #(.READBACK(1'b0)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(b0));
  jtag_az_pwm #(.READBACK(1'b1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int sel, input logic cap, input logic sh, input logic up, input logic td);
    if (sel == 0) begin
      b0.capture_dr = cap;
      b0.shift_dr = sh;
      b0.update_dr = up;
      b0.tdi = td;
    end else begin
      b1.capture_dr = cap;
      b1.shift_dr = sh;
      b1.update_dr = up;
      b1.tdi = td;
    end
  endtask
  task automatic shift_in(input int sel, input logic [27:0] v);
    for (int i = 0; i < 28; i++) begin
      drive(sel, 1'b0, 1'b1, 1'b0, v[i]);
      tick();
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic update(input int sel);
    drive(sel, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(sel, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  function automatic logic [27:0] mk(input logic e, input int nl, input int nh, input int nd);
    return {e, nl[13:0], nh[7:0], nd[4:0]};
  endfunction
  task automatic disable_dut(input int sel);
    logic a;
    shift_in(sel, 28'd0);
    update(sel);
    tick();
    a = (sel == 0) ? b0.az : b1.az;
    total++;
    if (a !== 1'b0) begin
      bad++;
      $display("FAIL disable dut%0d: az=%b want 0", sel, a);
    end
  endtask
  task automatic test_reset();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({b0.tdo, b0.az, b0.period_stb} !== 3'b000) begin
      bad++;
      $display("FAIL reset outs: tdo/az/stb=%b want 000", {b0.tdo, b0.az, b0.period_stb});
    end
    total++;
    if (b0.shadow !== 28'd0 || b1.shadow !== 28'd0) begin
      bad++;
      $display("FAIL reset shadow: got %h/%h want 0", b0.shadow, b1.shadow);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (b0.az !== 1'b0) begin
      bad++;
      $display("FAIL reset release az: got %b want 0", b0.az);
    end
  endtask
  task automatic test_capture();
    logic [27:0] exp = mk(1'b0, 3980, 20, 0);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 28; i++) begin
      total++;
      if (b0.tdo !== exp[i]) begin
        bad++;
        $display("FAIL capture bit %0d: tdo=%b want %b", i, b0.tdo, exp[i]);
      end
      drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (b0.shadow !== 28'd0) begin
      bad++;
      $display("FAIL capture shadow: got %h want 0", b0.shadow);
    end
  endtask
  task automatic test_basic();
    int p;
    logic [1:0] exp;
    shift_in(0, mk(1'b1, 3980, 20, 0));
    update(0);
    total++;
    if (b0.az !== 1'b0) begin
      bad++;
      $display("FAIL basic at update: az=%b want 0", b0.az);
    end
    for (int k = 1; k <= 8001; k++) begin
      tick();
      p = (k - 1) % 4000;
      exp = {p < 20, p == 3999};
      total++;
      if ({b0.az, b0.period_stb} !== exp) begin
        bad++;
        $display("FAIL basic k=%0d: az/stb=%b want %b", k, {b0.az, b0.period_stb}, exp);
      end
    end
    disable_dut(0);
  endtask
  task automatic test_delay();
    int p;
    logic [1:0] exp;
    shift_in(0, mk(1'b1, 4, 3, 5));
    update(0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      p = (k - 6) % 7;
      exp = (k < 6) ? 2'b00 : {p < 3, p == 6};
      total++;
      if ({b0.az, b0.period_stb} !== exp) begin
        bad++;
        $display("FAIL delay k=%0d: az/stb=%b want %b", k, {b0.az, b0.period_stb}, exp);
      end
    end
    disable_dut(0);
  endtask
  task automatic test_mid_update();
    int p;
    logic [1:0] exp;
    shift_in(0, mk(1'b1, 4, 3, 0));
    update(0);
    shift_in(0, mk(1'b1, 2, 2, 0));
    tick();
    update(0);
    total++;
    if (b0.az !== 1'b1) begin
      bad++;
      $display("FAIL midupd at update: az=%b want 1", b0.az);
    end
    for (int k = 31; k <= 50; k++) begin
      tick();
      p = (k < 36) ? (k - 1) % 7 : (k - 36) % 4;
      exp = (k < 36) ? {p < 3, p == 6} : {p < 2, p == 3};
      total++;
      if ({b0.az, b0.period_stb} !== exp) begin
        bad++;
        $display("FAIL midupd k=%0d: az/stb=%b want %b", k, {b0.az, b0.period_stb}, exp);
      end
    end
    disable_dut(0);
  endtask
  task automatic test_zero_phases();
    shift_in(0, mk(1'b1, 0, 0, 0));
    update(0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if ({b0.az, b0.period_stb} !== 2'b01) begin
        bad++;
        $display("FAIL zero both k=%0d: az/stb=%b want 01", k, {b0.az, b0.period_stb});
      end
    end
    disable_dut(0);
    shift_in(0, mk(1'b1, 0, 3, 0));
    update(0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if ({b0.az, b0.period_stb} !== 2'b10) begin
        bad++;
        $display("FAIL zero low k=%0d: az/stb=%b want 10", k, {b0.az, b0.period_stb});
      end
    end
    disable_dut(0);
  endtask
  task automatic test_readback();
    logic [27:0] v = mk(1'b1, 5, 0, 0);
    logic [2:0] exp;
    int k;
    shift_in(1, v);
    update(1);
    total++;
    if (b1.shadow !== v) begin
      bad++;
      $display("FAIL readback shadow: got %h want %h", b1.shadow, v);
    end
    drive(1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 28; i++) begin
      k = 1 + i;
      exp = {v[i], 1'b0, (k % 5) == 0};
      total++;
      if ({b1.tdo, b1.az, b1.period_stb} !== exp) begin
        bad++;
        $display("FAIL readback bit %0d: tdo/az/stb=%b want %b", i, {b1.tdo, b1.az, b1.period_stb}, exp);
      end
      drive(1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_reset_mid_high();
    shift_in(0, mk(1'b1, 4, 3, 0));
    update(0);
    tick();
    total++;
    if (b0.az !== 1'b1) begin
      bad++;
      $display("FAIL rst pre: az=%b want 1", b0.az);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({b0.az, b0.period_stb, b0.tdo} !== 3'b000 || b0.shadow !== 28'd0 || b1.shadow !== 28'd0) begin
      bad++;
      $display("FAIL rst mid-high: az/stb/tdo=%b shadow=%h/%h want 000 0/0", {b0.az, b0.period_stb, b0.tdo}, b0.shadow, b1.shadow);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      total++;
      if (b0.az !== 1'b0) begin
        bad++;
        $display("FAIL rst no restart k=%0d: az=%b want 0", k, b0.az);
      end
    end
  endtask
  initial begin
    test_reset();
    test_capture();
    test_basic();
    test_delay();
    test_mid_update();
    test_zero_phases();
    test_readback();
    test_reset_mid_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
